// File: rtl/main_mem_arbiter_if.sv
// Bus bundle between NCORE cores and the main-memory arbiter: per-core request/lock
// handshake on one side, the single-port memory macro on the other.
interface main_mem_arbiter_if #(
    parameter int NCORE = 2
);
    logic [NCORE-1:0]    rd_req;
    logic [NCORE-1:0]    wr_req;
    logic [16*NCORE-1:0] req_addr;
    logic [16*NCORE-1:0] req_wdata;
    logic [NCORE-1:0]    lock_req;
    logic [NCORE-1:0]    unlock_req;
    logic [NCORE-1:0]    done;
    logic [15:0]         rdata;
    logic [NCORE-1:0]    lock_ack;
    logic [3:0]          lock_owner;
    logic [15:0]         mem_addr;
    logic [15:0]         mem_wdata;
    logic                mem_re;
    logic                mem_we;
    logic [15:0]         mem_rdata;
    logic                lock_timeout;

    modport master (
        output rd_req, wr_req, req_addr, req_wdata, lock_req, unlock_req, mem_rdata,
        input  done, rdata, lock_ack, lock_owner, mem_addr, mem_wdata, mem_re, mem_we,
               lock_timeout
    );

    modport slave (
        input  rd_req, wr_req, req_addr, req_wdata, lock_req, unlock_req, mem_rdata,
        output done, rdata, lock_ack, lock_owner, mem_addr, mem_wdata, mem_re, mem_we,
               lock_timeout
    );
endinterface

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NCORE cores, with a LOCK/UNLOCK
// semaphore. Define ARB_TIMEOUT_EN to build the lock watchdog (LOCK_TIMEOUT cycles).
//
// state | meaning
// IDLE  | arbitrate; done pulse of the previous access is visible here
// WRITE | mem_we asserted for the latched core
// READ  | mem_re asserted for the latched core
// RWAIT | waiting RD_LAT cycles, capture mem_rdata on the last one
module main_mem_arbiter #(
    parameter int NCORE        = 2,
    parameter int RD_LAT       = 1,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    main_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

    function automatic logic [2:0] rr_pick(input logic [NCORE-1:0] mask, input logic [2:0] start);
        logic [2:0] pick;
        logic       hit;
        pick = 3'd0;
        hit  = 1'b0;
        for (int k = 0; k < NCORE; k++)
            for (int i = 0; i < NCORE; i++)
                if (!hit && mask[i] && ((int'(start) + k) % NCORE) == i) begin
                    pick = 3'(i);
                    hit  = 1'b1;
                end
        return pick;
    endfunction

    function automatic logic [NCORE-1:0] onehot(input logic [2:0] id);
        return NCORE'(1) << id;
    endfunction

    function automatic logic [2:0] next_id(input logic [2:0] id);
        return (id == 3'(NCORE - 1)) ? 3'd0 : id + 3'd1;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       cur_q, cur_d, rr_q, rr_d, wait_q, wait_d, pick;
    logic [15:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_addr, sel_wdata;
    logic [NCORE-1:0] done_q, done_d, elig, own_oh;

    logic             lock_valid_q, lock_valid_d;
    logic [2:0]       owner_q, owner_d;
    logic [NCORE-1:0] ack_q, ack_d;

    assign own_oh = onehot(owner_q);
    // A core whose done is pulsing still holds its request this cycle; keep it out of the scan.
    assign elig   = (bus.rd_req | bus.wr_req) & ~done_q & (lock_valid_q ? own_oh : '1);
    assign pick   = rr_pick(elig, rr_q);

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCORE; i++)
            if (3'(i) == pick) begin
                sel_addr  = bus.req_addr[16*i +: 16];
                sel_wdata = bus.req_wdata[16*i +: 16];
            end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        case (state_q)
            IDLE: if (|elig) begin
                cur_d   = pick;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                state_d = (|(bus.wr_req & onehot(pick))) ? WRITE : READ;
            end
            WRITE: begin
                done_d  = onehot(cur_q);
                rr_d    = next_id(cur_q);
                state_d = IDLE;
            end
            READ: begin
                wait_d  = 3'(RD_LAT - 1);
                state_d = RWAIT;
            end
            RWAIT: if (wait_q == 3'd0) begin
                rdata_d = bus.mem_rdata;
                done_d  = onehot(cur_q);
                rr_d    = next_id(cur_q);
                state_d = IDLE;
            end else begin
                wait_d = wait_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_re    = (state_q == READ);
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_addr  = (state_q == IDLE) ? 16'h0 : addr_q;
    assign bus.mem_wdata = (state_q == IDLE) ? 16'h0 : wdata_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            owner_q      <= '0;
            ack_q        <= '0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q       <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            lock_valid_q <= lock_valid_d;
            owner_q      <= owner_d;
            ack_q        <= ack_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    // Releases only free the lock; a new grant is evaluated against the registered free state.
    always_comb begin
        lock_valid_d = lock_valid_q;
        owner_d      = owner_q;
        ack_d        = '0;
`ifdef ARB_TIMEOUT_EN
        tcnt_d       = tcnt_q;
        tmo_d        = 1'b0;
`endif
        if (lock_valid_q) begin
            if (|(bus.unlock_req & own_oh)) begin
                lock_valid_d = 1'b0;
                owner_d      = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tcnt_q == '0) begin
                lock_valid_d = 1'b0;
                owner_d      = '0;
                tmo_d        = 1'b1;
            end
`endif
            else if (|(bus.lock_req & own_oh & ~ack_q)) begin
                ack_d = own_oh;
            end
`ifdef ARB_TIMEOUT_EN
            tcnt_d = lock_valid_d ? tcnt_q - TW'(1) : '0;
`endif
        end else if (|bus.lock_req) begin
            owner_d      = rr_pick(bus.lock_req, rr_q);
            lock_valid_d = 1'b1;
            ack_d        = onehot(owner_d);
`ifdef ARB_TIMEOUT_EN
            tcnt_d       = TW'(LOCK_TIMEOUT - 1);
`endif
        end
    end

    assign bus.lock_ack   = ack_q;
    assign bus.lock_owner = {lock_valid_q, owner_q};
`ifdef ARB_TIMEOUT_EN
    assign bus.lock_timeout = tmo_q;
`else
    assign bus.lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed-vector bench for main_mem_arbiter with a simple RD_LAT=1 memory model;
// the watchdog scenario is built when ARB_TIMEOUT_EN is defined.
module tb_main_mem_arbiter;
    localparam int NCORE  = 2;
    localparam int RD_LAT = 1;
`ifdef ARB_TIMEOUT_EN
    localparam int LOCK_TIMEOUT = 8;
`else
    localparam int LOCK_TIMEOUT = 1024;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    main_mem_arbiter_if #(.NCORE(NCORE)) bus();

    main_mem_arbiter #(
        .NCORE(NCORE), .RD_LAT(RD_LAT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Memory model: unwritten words read back as 16'hA500 | addr[7:0].
    logic [15:0]  mem [256];
    logic [255:0] wvld = '0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]]  <= bus.mem_wdata;
            wvld[bus.mem_addr[7:0]] <= 1'b1;
        end
        if (bus.mem_re)
            bus.mem_rdata <= wvld[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]]
                                                     : (16'hA500 | {8'h00, bus.mem_addr[7:0]});
        else
            bus.mem_rdata <= 16'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.rd_req     = '0;
        bus.wr_req     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.lock_req   = '0;
        bus.unlock_req = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.mem_rdata = '0;
        do_reset();

        // reset state
        chk("rst_done", bus.done, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_owner", bus.lock_owner, 0);
        chk("rst_ack", bus.lock_ack, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_tmo", bus.lock_timeout, 0);

        // core 0 write then read back
        bus.wr_req    = 2'b01;
        bus.req_addr  = {16'h0000, 16'h0010};
        bus.req_wdata = {16'h0000, 16'hBEEF};
        tick();
        chk("wr_we", bus.mem_we, 1);
        chk("wr_addr", bus.mem_addr, 16'h0010);
        chk("wr_data", bus.mem_wdata, 16'hBEEF);
        chk("wr_done_early", bus.done, 0);
        tick();
        chk("wr_done", bus.done, 2'b01);
        chk("wr_we_off", bus.mem_we, 0);
        chk("wr_addr_idle", bus.mem_addr, 0);
        bus.wr_req = '0;
        tick();
        bus.rd_req = 2'b01;
        tick();
        chk("rd_re", bus.mem_re, 1);
        chk("rd_addr", bus.mem_addr, 16'h0010);
        tick();
        chk("rd_done_early", bus.done, 0);
        tick();
        chk("rd_done", bus.done, 2'b01);
        chk("rd_data", bus.rdata, 16'hBEEF);
        bus.rd_req = '0;

        // two cores reading continuously alternate
        do_reset();
        bus.rd_req   = 2'b11;
        bus.req_addr = {16'h0030, 16'h0020};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_re", bus.mem_re, 1);
            chk("rr_addr", bus.mem_addr, (k % 2) ? 16'h0030 : 16'h0020);
            tick();
            tick();
            chk("rr_done", bus.done, (k % 2) ? 2'b10 : 2'b01);
            chk("rr_data", bus.rdata, (k % 2) ? 16'hA530 : 16'hA520);
        end
        bus.rd_req = '0;
        tick();
        chk("rr_stop", bus.mem_re, 0);

        // core 1 lock excludes core 0; non-owner unlock ignored
        do_reset();
        bus.lock_req = 2'b10;
        tick();
        chk("lk_ack", bus.lock_ack, 2'b10);
        chk("lk_owner", bus.lock_owner, 4'b1001);
        bus.lock_req = '0;
        tick();
        chk("lk_noreack", bus.lock_ack, 0);
        bus.wr_req    = 2'b11;
        bus.req_addr  = {16'h0041, 16'h0040};
        bus.req_wdata = {16'h5555, 16'hAAAA};
        tick();
        chk("lk_c1_we", bus.mem_we, 1);
        chk("lk_c1_addr", bus.mem_addr, 16'h0041);
        chk("lk_c1_data", bus.mem_wdata, 16'h5555);
        tick();
        chk("lk_c1_done", bus.done, 2'b10);
        bus.wr_req     = 2'b01;
        bus.unlock_req = 2'b01;
        tick();
        chk("lk_c0_blocked", bus.mem_we, 0);
        chk("lk_bad_unlock", bus.lock_owner, 4'b1001);
        bus.unlock_req = 2'b10;
        tick();
        chk("lk_free", bus.lock_owner, 0);
        chk("lk_free_we", bus.mem_we, 0);
        bus.unlock_req = '0;
        tick();
        chk("lk_c0_we", bus.mem_we, 1);
        chk("lk_c0_addr", bus.mem_addr, 16'h0040);
        chk("lk_c0_data", bus.mem_wdata, 16'hAAAA);
        tick();
        chk("lk_c0_done", bus.done, 2'b01);
        bus.wr_req = '0;

        // simultaneous lock requests with rr=1
        bus.lock_req = 2'b11;
        tick();
        chk("sl_ack1", bus.lock_ack, 2'b10);
        chk("sl_owner1", bus.lock_owner, 4'b1001);
        bus.lock_req = 2'b01;
        tick();
        chk("sl_wait", bus.lock_ack, 0);
        bus.unlock_req = 2'b10;
        tick();
        chk("sl_released", bus.lock_owner, 0);
        chk("sl_no_early", bus.lock_ack, 0);
        bus.unlock_req = '0;
        tick();
        chk("sl_ack0", bus.lock_ack, 2'b01);
        chk("sl_owner0", bus.lock_owner, 4'b1000);
        bus.lock_req = '0;

        // reset during a read's wait cycle, with core 0 holding the lock
        bus.rd_req   = 2'b01;
        bus.req_addr = {16'h0000, 16'h0020};
        tick();
        chk("mr_re", bus.mem_re, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("mr_re_off", bus.mem_re, 0);
        chk("mr_we_off", bus.mem_we, 0);
        chk("mr_nodone", bus.done, 0);
        chk("mr_owner", bus.lock_owner, 0);
        chk("mr_addr", bus.mem_addr, 0);
        tick();
        chk("mr_nodone2", bus.done, 0);
        reset = 1'b0;
        bus.rd_req = '0;

        do_reset();
        bus.lock_req = 2'b01;
        tick();
        chk("to_ack0", bus.lock_ack, 2'b01);
`ifdef ARB_TIMEOUT_EN
        bus.lock_req = 2'b10;
        repeat (7) tick();
        chk("to_held", bus.lock_owner, 4'b1000);
        chk("to_not_yet", bus.lock_timeout, 0);
        tick();
        chk("to_pulse", bus.lock_timeout, 1);
        chk("to_released", bus.lock_owner, 0);
        tick();
        chk("to_ack1", bus.lock_ack, 2'b10);
        chk("to_owner1", bus.lock_owner, 4'b1001);
        chk("to_pulse_end", bus.lock_timeout, 0);
`else
        bus.lock_req = '0;
        repeat (20) tick();
        chk("to_held", bus.lock_owner, 4'b1000);
        chk("to_tied", bus.lock_timeout, 0);
`endif
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
